mc_cu: RTL and testbench

MC_CU -- requirements
Module: mc_cu

---
 rtl/mc_cu.sv | 199 +++++++++++++++++++
 tb/tb_mc_cu.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_cu.sv
// rtl/mc_cu.sv - multicycle MIPS-subset control unit (IF/ID/EXE/MEM/WB)
module mc_cu #(
  parameter int MEM_HS = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_ready,
  output logic       wpc,
  output logic       wir,
  output logic       wreg,
  output logic       jal,
  output logic       wmem,
  output logic       iord,
  output logic       m2reg,
  output logic [3:0] aluc,
  output logic       shift,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       sext,
  output logic       regrt,
  output logic [1:0] pcsource,
  output logic [2:0] state,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  state_t     state_q, state_d;
  logic       ready;
  logic       d_rtype, d_shift, d_jr, d_ialu, d_addi;
  logic       d_lw, d_sw, d_beq, d_bne, d_j, d_jal, d_legal;
  logic [3:0] d_aluc;

  // Without the handshake the memory is taken as completing every cycle
  assign ready = (MEM_HS != 0) ? mem_ready : 1'b1;
  assign state = state_q;

  // Classify the instruction and pick its ALU operation
  always_comb begin
    d_rtype = 1'b0;
    d_shift = 1'b0;
    d_jr    = 1'b0;
    d_ialu  = 1'b0;
    d_addi  = 1'b0;
    d_lw    = 1'b0;
    d_sw    = 1'b0;
    d_beq   = 1'b0;
    d_bne   = 1'b0;
    d_j     = 1'b0;
    d_jal   = 1'b0;
    d_aluc  = ALU_ADD;
    case (op)
      6'b000000: begin
        case (func)
          6'b100000: begin d_rtype = 1'b1; d_aluc = ALU_ADD; end
          6'b100010: begin d_rtype = 1'b1; d_aluc = ALU_SUB; end
          6'b100100: begin d_rtype = 1'b1; d_aluc = ALU_AND; end
          6'b100101: begin d_rtype = 1'b1; d_aluc = ALU_OR;  end
          6'b100110: begin d_rtype = 1'b1; d_aluc = ALU_XOR; end
          6'b000000: begin d_rtype = 1'b1; d_shift = 1'b1; d_aluc = ALU_SLL; end
          6'b000010: begin d_rtype = 1'b1; d_shift = 1'b1; d_aluc = ALU_SRL; end
          6'b000011: begin d_rtype = 1'b1; d_shift = 1'b1; d_aluc = ALU_SRA; end
          6'b001000: d_jr = 1'b1;
          default:   ;
        endcase
      end
      6'b001000: begin d_ialu = 1'b1; d_addi = 1'b1; d_aluc = ALU_ADD; end
      6'b001100: begin d_ialu = 1'b1; d_aluc = ALU_AND; end
      6'b001101: begin d_ialu = 1'b1; d_aluc = ALU_OR;  end
      6'b001110: begin d_ialu = 1'b1; d_aluc = ALU_XOR; end
      6'b001111: begin d_ialu = 1'b1; d_aluc = ALU_LUI; end
      6'b100011: d_lw  = 1'b1;
      6'b101011: d_sw  = 1'b1;
      6'b000100: d_beq = 1'b1;
      6'b000101: d_bne = 1'b1;
      6'b000010: d_j   = 1'b1;
      6'b000011: d_jal = 1'b1;
      default:   ;
    endcase
    d_legal = d_rtype | d_jr | d_ialu | d_lw | d_sw | d_beq | d_bne | d_j | d_jal;
  end

  // State register; reset aborts whatever instruction is in flight
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // Next state and per-state control word
  always_comb begin
    state_d  = S_IF;
    wpc      = 1'b0;
    wir      = 1'b0;
    wreg     = 1'b0;
    jal      = 1'b0;
    wmem     = 1'b0;
    iord     = 1'b0;
    m2reg    = 1'b0;
    aluc     = ALU_ADD;
    shift    = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    sext     = 1'b0;
    regrt    = 1'b0;
    pcsource = 2'b00;
    illegal  = 1'b0;
    case (state_q)
      S_IF: begin
        alusrcb = 2'b01;
        wpc     = ready;
        wir     = ready;
        state_d = ready ? S_ID : S_IF;
      end
      S_ID: begin
        if (d_j || d_jal) begin
          pcsource = 2'b11;
          wpc      = 1'b1;
          wreg     = d_jal;
          jal      = d_jal;
        end else if (d_jr) begin
          pcsource = 2'b10;
          wpc      = 1'b1;
        end else if (!d_legal) begin
          illegal  = 1'b1;
        end else begin
          alusrcb  = 2'b11;
          sext     = 1'b1;
          state_d  = S_EXE;
        end
      end
      S_EXE: begin
        if (d_beq || d_bne) begin
          alusrca  = 1'b1;
          aluc     = ALU_SUB;
          pcsource = 2'b01;
          wpc      = (d_beq & z) | (d_bne & ~z);
        end else if (d_lw || d_sw) begin
          alusrca  = 1'b1;
          alusrcb  = 2'b10;
          sext     = 1'b1;
          state_d  = S_MEM;
        end else if (d_rtype) begin
          alusrca  = 1'b1;
          aluc     = d_aluc;
          shift    = d_shift;
          state_d  = S_WB;
        end else if (d_ialu) begin
          alusrcb  = 2'b10;
          regrt    = 1'b1;
          sext     = d_addi;
          aluc     = d_aluc;
          state_d  = S_WB;
        end
      end
      S_MEM: begin
        iord = 1'b1;
        if (d_sw) begin
          wmem    = 1'b1;
          state_d = ready ? S_IF : S_MEM;
        end else if (d_lw) begin
          state_d = ready ? S_WB : S_MEM;
        end
      end
      S_WB: begin
        wreg  = 1'b1;
        m2reg = d_lw;
        regrt = d_lw | d_ialu;
      end
      default: state_d = S_IF;
    endcase
    if (reset) begin
      wpc     = 1'b0;
      wir     = 1'b0;
      wreg    = 1'b0;
      wmem    = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_cu.sv
// tb/tb_mc_cu.sv - randomized model-checked bench for mc_cu (handshake and no-handshake builds)
module tb_mc_cu;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [5:0] op, func;
  logic       z, mem_ready;

  logic h_wpc, h_wir, h_wreg, h_jal, h_wmem, h_iord, h_m2reg, h_shift, h_alusrca, h_sext, h_regrt, h_illegal;
  logic [3:0] h_aluc;
  logic [1:0] h_alusrcb, h_pcsource;
  logic [2:0] h_state;
  logic n_wpc, n_wir, n_wreg, n_jal, n_wmem, n_iord, n_m2reg, n_shift, n_alusrca, n_sext, n_regrt, n_illegal;
  logic [3:0] n_aluc;
  logic [1:0] n_alusrcb, n_pcsource;
  logic [2:0] n_state;

  mc_cu #(.MEM_HS(1)) u_hs (
    .clock(clock), .reset(reset), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
    .wpc(h_wpc), .wir(h_wir), .wreg(h_wreg), .jal(h_jal), .wmem(h_wmem), .iord(h_iord),
    .m2reg(h_m2reg), .aluc(h_aluc), .shift(h_shift), .alusrca(h_alusrca), .alusrcb(h_alusrcb),
    .sext(h_sext), .regrt(h_regrt), .pcsource(h_pcsource), .state(h_state), .illegal(h_illegal)
  );

  mc_cu #(.MEM_HS(0)) u_nh (
    .clock(clock), .reset(reset), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
    .wpc(n_wpc), .wir(n_wir), .wreg(n_wreg), .jal(n_jal), .wmem(n_wmem), .iord(n_iord),
    .m2reg(n_m2reg), .aluc(n_aluc), .shift(n_shift), .alusrca(n_alusrca), .alusrcb(n_alusrcb),
    .sext(n_sext), .regrt(n_regrt), .pcsource(n_pcsource), .state(n_state), .illegal(n_illegal)
  );

  logic [22:0] obs_h, obs_n, exp_h, exp_n;
  assign obs_h = {h_wpc, h_wir, h_wreg, h_jal, h_wmem, h_iord, h_m2reg, h_aluc, h_shift, h_alusrca,
                  h_alusrcb, h_sext, h_regrt, h_pcsource, h_state, h_illegal};
  assign obs_n = {n_wpc, n_wir, n_wreg, n_jal, n_wmem, n_iord, n_m2reg, n_aluc, n_shift, n_alusrca,
                  n_alusrcb, n_sext, n_regrt, n_pcsource, n_state, n_illegal};

  int checks = 0;
  int errors = 0;
  int ms_h, ms_n, nx_h, nx_n;

  localparam int C_ILL = 0, C_R = 1, C_SH = 2, C_JR = 3, C_I = 4, C_LW = 5;
  localparam int C_SW = 6, C_BEQ = 7, C_BNE = 8, C_J = 9, C_JAL = 10;

  logic [5:0] tbl_op [0:19] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h0f, 6'h02, 6'h03};
  logic [5:0] tbl_fn [0:19] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03, 6'h08,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  function automatic int cls(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) begin
      if (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h26) return C_R;
      if (f == 6'h00 || f == 6'h02 || f == 6'h03) return C_SH;
      if (f == 6'h08) return C_JR;
      return C_ILL;
    end
    if (o == 6'h08 || o == 6'h0c || o == 6'h0d || o == 6'h0e || o == 6'h0f) return C_I;
    if (o == 6'h23) return C_LW;
    if (o == 6'h2b) return C_SW;
    if (o == 6'h04) return C_BEQ;
    if (o == 6'h05) return C_BNE;
    if (o == 6'h02) return C_J;
    if (o == 6'h03) return C_JAL;
    return C_ILL;
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] o, input logic [5:0] f);
    logic [5:0] k;
    k = (o == 6'h00) ? f : o;
    if (o == 6'h00) begin
      case (k)
        6'h20: return 4'b0000;  6'h22: return 4'b0100;  6'h24: return 4'b0001;
        6'h25: return 4'b0101;  6'h26: return 4'b0010;  6'h00: return 4'b0011;
        6'h02: return 4'b0111;  6'h03: return 4'b1111;  default: return 4'b0000;
      endcase
    end
    case (k)
      6'h08: return 4'b0000;  6'h0c: return 4'b0001;  6'h0d: return 4'b0101;
      6'h0e: return 4'b0010;  6'h0f: return 4'b0110;  default: return 4'b0000;
    endcase
  endfunction

  // Returns {next_state[2:0], expected 23-bit control word}
  function automatic logic [25:0] model(input int st, input logic [5:0] o, input logic [5:0] f,
                                        input logic zi, input logic rdy, input logic rst);
    logic e_wpc, e_wir, e_wreg, e_jal, e_wmem, e_iord, e_m2reg, e_shift, e_asa, e_sext, e_regrt, e_ill;
    logic [3:0] e_aluc;
    logic [1:0] e_asb, e_pcs;
    int nx, c;
    logic [2:0] s3, n3;
    c = cls(o, f);
    {e_wpc, e_wir, e_wreg, e_jal, e_wmem, e_iord, e_m2reg, e_shift, e_asa, e_sext, e_regrt, e_ill} = '0;
    e_aluc = 4'b0000; e_asb = 2'b00; e_pcs = 2'b00; nx = 0;
    case (st)
      0: begin e_asb = 2'b01; e_wpc = rdy; e_wir = rdy; nx = rdy ? 1 : 0; end
      1: begin
        if (c == C_J || c == C_JAL) begin
          e_pcs = 2'b11; e_wpc = 1'b1;
          if (c == C_JAL) begin e_wreg = 1'b1; e_jal = 1'b1; end
        end else if (c == C_JR) begin
          e_pcs = 2'b10; e_wpc = 1'b1;
        end else if (c == C_ILL) begin
          e_ill = 1'b1;
        end else begin
          e_asb = 2'b11; e_sext = 1'b1; nx = 2;
        end
      end
      2: begin
        if (c == C_BEQ || c == C_BNE) begin
          e_asa = 1'b1; e_aluc = 4'b0100; e_pcs = 2'b01;
          e_wpc = (c == C_BEQ) ? zi : !zi;
        end else if (c == C_LW || c == C_SW) begin
          e_asa = 1'b1; e_asb = 2'b10; e_sext = 1'b1; nx = 3;
        end else if (c == C_R || c == C_SH) begin
          e_asa = 1'b1; e_aluc = alu_of(o, f); e_shift = (c == C_SH); nx = 4;
        end else if (c == C_I) begin
          e_asb = 2'b10; e_regrt = 1'b1; e_sext = (o == 6'h08); e_aluc = alu_of(o, f); nx = 4;
        end
      end
      3: begin
        e_iord = 1'b1;
        if (c == C_SW) begin e_wmem = 1'b1; nx = rdy ? 0 : 3; end
        else if (c == C_LW) nx = rdy ? 4 : 3;
      end
      4: begin e_wreg = 1'b1; e_m2reg = (c == C_LW); e_regrt = (c == C_LW || c == C_I); end
      default: nx = 0;
    endcase
    if (rst) begin
      e_wpc = 1'b0; e_wir = 1'b0; e_wreg = 1'b0; e_wmem = 1'b0; e_ill = 1'b0; nx = 0;
    end
    s3 = st[2:0];
    n3 = nx[2:0];
    return {n3, e_wpc, e_wir, e_wreg, e_jal, e_wmem, e_iord, e_m2reg, e_aluc, e_shift, e_asa,
            e_asb, e_sext, e_regrt, e_pcs, s3, e_ill};
  endfunction

  task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic zi, input logic mri, input logic rsti);
    logic [25:0] rh, rn;
    op = o; func = f; z = zi; mem_ready = mri; reset = rsti;
    @(negedge clock);
    rh = model(ms_h, o, f, zi, mri, rsti);
    rn = model(ms_n, o, f, zi, 1'b1, rsti);
    exp_h = rh[22:0]; nx_h = int'(rh[25:23]);
    exp_n = rn[22:0]; nx_n = int'(rn[25:23]);
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
    ms_h = nx_h;
    ms_n = nx_n;
  endtask

  task automatic resync();
    drive(6'h00, 6'h20, 1'b0, 1'b0, 1'b1);
    checks += 2;
    if (obs_h !== exp_h) begin errors++; $display("FAIL resync_hs actual=%h expected=%h", obs_h, exp_h); end
    if (obs_n !== exp_n) begin errors++; $display("FAIL resync_nh actual=%h expected=%h", obs_n, exp_n); end
    adv();
  endtask

  task automatic test_reset();
    drive(6'h00, 6'h00, 1'b0, 1'b0, 1'b1);
    @(posedge clock); #1;
    ms_h = 0; ms_n = 0;
    for (int i = 0; i < 3; i++) begin
      drive(6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      checks += 3;
      if (obs_h !== exp_h) begin errors++; $display("FAIL reset_hs actual=%h expected=%h", obs_h, exp_h); end
      if (obs_n !== exp_n) begin errors++; $display("FAIL reset_nh actual=%h expected=%h", obs_n, exp_n); end
      if ({h_state, h_wpc, h_wir, h_wreg, h_wmem, h_illegal} !== 8'd0)
        begin errors++; $display("FAIL reset_idle actual=%b required=0", {h_state, h_wpc, h_wir, h_wreg, h_wmem, h_illegal}); end
      adv();
    end
  endtask

  task automatic test_add_nh();
    int seq [4] = '{0, 1, 2, 4};
    resync();
    for (int i = 0; i < 5; i++) begin
      drive(6'h00, 6'h20, 1'($urandom), 1'b0, 1'b0);
      checks += 4;
      if (obs_n !== exp_n) begin errors++; $display("FAIL add_nh_model cyc=%0d actual=%h expected=%h", i, obs_n, exp_n); end
      if (obs_h !== exp_h) begin errors++; $display("FAIL add_hs_stall cyc=%0d actual=%h expected=%h", i, obs_h, exp_h); end
      if (n_state !== ((i < 4) ? 3'(seq[i]) : 3'd0)) begin errors++; $display("FAIL add_state cyc=%0d actual=%0d", i, n_state); end
      if (n_wreg !== (i == 3) || n_aluc !== 4'b0000)
        begin errors++; $display("FAIL add_wreg_aluc cyc=%0d actual=%b/%b", i, n_wreg, n_aluc); end
      adv();
    end
  endtask

  task automatic test_lw_wait();
    logic mr [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int   st [8] = '{0, 1, 2, 3, 3, 3, 3, 4};
    resync();
    for (int i = 0; i < 8; i++) begin
      drive(6'h23, 6'($urandom), 1'($urandom), mr[i], 1'b0);
      checks += 3;
      if (obs_h !== exp_h) begin errors++; $display("FAIL lw_model cyc=%0d actual=%h expected=%h", i, obs_h, exp_h); end
      if (obs_n !== exp_n) begin errors++; $display("FAIL lw_nh cyc=%0d actual=%h expected=%h", i, obs_n, exp_n); end
      if (h_state !== 3'(st[i])) begin errors++; $display("FAIL lw_state cyc=%0d actual=%0d required=%0d", i, h_state, st[i]); end
      if (i == 7) begin
        checks++;
        if ({h_m2reg, h_wreg} !== 2'b11) begin errors++; $display("FAIL lw_wb actual=%b required=11", {h_m2reg, h_wreg}); end
      end
      adv();
    end
  endtask

  task automatic test_branch();
    for (int k = 0; k < 4; k++) begin
      logic [5:0] o;
      logic zi, want;
      o = (k < 2) ? 6'h04 : 6'h05;
      zi = k[0];
      want = (k < 2) ? zi : !zi;
      resync();
      for (int i = 0; i < 4; i++) begin
        drive(o, 6'($urandom), zi, 1'b1, 1'b0);
        checks += 2;
        if (obs_h !== exp_h) begin errors++; $display("FAIL br_model k=%0d cyc=%0d actual=%h expected=%h", k, i, obs_h, exp_h); end
        if (obs_n !== exp_n) begin errors++; $display("FAIL br_nh k=%0d cyc=%0d actual=%h expected=%h", k, i, obs_n, exp_n); end
        if (i == 2) begin
          checks++;
          if ({h_state, h_wpc, h_pcsource} !== {3'd2, want, 2'b01})
            begin errors++; $display("FAIL br_exe k=%0d actual=%b required=%b", k, {h_state, h_wpc, h_pcsource}, {3'd2, want, 2'b01}); end
        end
        if (i == 3) begin
          checks++;
          if (h_state !== 3'd0) begin errors++; $display("FAIL br_return k=%0d actual=%0d", k, h_state); end
        end
        adv();
      end
    end
  endtask

  task automatic test_jal();
    resync();
    for (int i = 0; i < 3; i++) begin
      drive(6'h03, 6'($urandom), 1'($urandom), 1'b1, 1'b0);
      checks++;
      if (obs_h !== exp_h) begin errors++; $display("FAIL jal_model cyc=%0d actual=%h expected=%h", i, obs_h, exp_h); end
      if (i == 1) begin
        checks++;
        if ({h_state, h_wpc, h_wreg, h_jal, h_pcsource} !== {3'd1, 3'b111, 2'b11})
          begin errors++; $display("FAIL jal_id actual=%b", {h_state, h_wpc, h_wreg, h_jal, h_pcsource}); end
      end
      if (i == 2) begin
        checks++;
        if (h_state !== 3'd0) begin errors++; $display("FAIL jal_return actual=%0d required=0", h_state); end
      end
      adv();
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [2] = '{6'h3f, 6'h00};
    logic [5:0] fns [2] = '{6'h15, 6'h3f};
    for (int k = 0; k < 2; k++) begin
      resync();
      for (int i = 0; i < 3; i++) begin
        drive(ops[k], fns[k], 1'b0, 1'b1, 1'b0);
        checks += 2;
        if (obs_h !== exp_h) begin errors++; $display("FAIL ill_model k=%0d cyc=%0d actual=%h expected=%h", k, i, obs_h, exp_h); end
        if ({h_illegal, h_wpc, h_wir, h_wreg, h_wmem, h_state} !==
            ((i == 1) ? {5'b10000, 3'd1} : (i == 0) ? {5'b01100, 3'd0} : {5'b01100, 3'd0}))
          begin errors++; $display("FAIL ill_pulse k=%0d cyc=%0d actual=%b", k, i, {h_illegal, h_wpc, h_wir, h_wreg, h_wmem, h_state}); end
        adv();
      end
    end
  endtask

  task automatic test_reset_in_mem();
    logic mr [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic rs [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    resync();
    for (int i = 0; i < 6; i++) begin
      drive(6'h2b, 6'h00, 1'b0, mr[i], rs[i]);
      checks += 2;
      if (obs_h !== exp_h) begin errors++; $display("FAIL swrst_model cyc=%0d actual=%h expected=%h", i, obs_h, exp_h); end
      if (i >= 3 && (h_state !== 3'd3 || h_wmem !== !rs[i]))
        begin errors++; $display("FAIL swrst_wmem cyc=%0d actual=%0d/%b required=3/%b", i, h_state, h_wmem, !rs[i]); end
      adv();
    end
    drive(6'h2b, 6'h00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (h_state !== 3'd0) begin errors++; $display("FAIL swrst_state actual=%0d required=0", h_state); end
    adv();
  endtask

  task automatic test_latency();
    logic [5:0] ops [11] = '{6'h02, 6'h03, 6'h00, 6'h04, 6'h05, 6'h00, 6'h00, 6'h08, 6'h0f, 6'h2b, 6'h23};
    logic [5:0] fns [11] = '{6'h00, 6'h00, 6'h08, 6'h00, 6'h00, 6'h20, 6'h03, 6'h00, 6'h00, 6'h00, 6'h00};
    int lat [11] = '{2, 2, 2, 3, 3, 4, 4, 4, 4, 4, 5};
    for (int k = 0; k < 11; k++) begin
      int n;
      resync();
      n = 11;
      for (int c = 0; c <= 10; c++) begin
        drive(ops[k], fns[k], 1'b1, 1'b0, 1'b0);
        if (c > 0 && n_state === 3'd0) begin n = c; break; end
        checks++;
        if (obs_n !== exp_n) begin errors++; $display("FAIL lat_model k=%0d cyc=%0d actual=%h expected=%h", k, c, obs_n, exp_n); end
        adv();
      end
      checks++;
      if (n !== lat[k]) begin errors++; $display("FAIL latency op=%h fn=%h actual=%0d required=%0d", ops[k], fns[k], n, lat[k]); end
    end
  endtask

  task automatic test_random();
    logic [5:0] o, f;
    resync();
    o = 6'h00; f = 6'h20;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) begin
        if ($urandom_range(9) < 8) begin
          int j = $urandom_range(19);
          o = tbl_op[j]; f = tbl_fn[j];
        end else begin
          o = 6'($urandom); f = 6'($urandom);
        end
      end
      drive(o, f, 1'($urandom), ($urandom_range(3) != 0), ($urandom_range(49) == 0));
      checks += 2;
      if (obs_h !== exp_h) begin errors++; $display("FAIL rand_hs cyc=%0d actual=%h expected=%h", i, obs_h, exp_h); end
      if (obs_n !== exp_n) begin errors++; $display("FAIL rand_nh cyc=%0d actual=%h expected=%h", i, obs_n, exp_n); end
      adv();
    end
  endtask

  initial begin
    reset = 1'b1; op = '0; func = '0; z = 1'b0; mem_ready = 1'b0;
    ms_h = 0; ms_n = 0; nx_h = 0; nx_n = 0;
    test_reset();
    test_add_nh();
    test_lw_wait();
    test_branch();
    test_jal();
    test_illegal();
    test_reset_in_mem();
    test_latency();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
